// File: rtl/tx_dma_req_split.sv
// tx_dma_req_split: announces each host buffer to the fill tracker, then splits it into MRRS- and 4KB-bounded PCIe reads.
// Optional feature macro TX_REQ_OUTSTANDING_LIMIT_EN adds the in-flight counter, MAX_OUTSTANDING throttle and underflow flag.
`timescale 1ns/1ps
module tx_dma_req_split #(
  parameter int WIDTH           = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  s_ul_clk,
  input  logic                  reset,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic [WIDTH-1:0]      desc_size,
  input  logic [4:0]            desc_idx,
  input  logic [2:0]            cfg_mrrs,
  output logic                  incb_valid,
  input  logic                  incb_ready,
  output logic [WIDTH-1:0]      incb_size,
  output logic [4:0]            incb_idx,
  output logic                  rq_valid,
  input  logic                  rq_ready,
  output logic [ADDR_WIDTH-1:0] rq_addr,
  output logic [10:0]           rq_len_dw,
  output logic [4:0]            rq_idx,
  output logic                  rq_last,
  input  logic                  cpl_done,
  output logic [3:0]            outstanding,
  output logic                  busy,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {IDLE, ANNOUNCE, SPLIT, ISSUE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [WIDTH-1:0]      remaining_q, remaining_d;
  logic [4:0]            cur_idx_q, cur_idx_d;
  logic [12:0]           chunk_q, chunk_d;

  logic [12:0]           mrrs_bytes;
  logic [12:0]           bnd_bytes;
  logic [WIDTH-1:0]      chunk_w;
  logic                  throttled;
  logic                  rq_hs;
  logic                  unused_lsb;

  // Descriptor address/size are DWORD granular; the low bits are dropped on capture.
  assign unused_lsb = ^{desc_addr[1:0], desc_size[1:0]};

  always_comb begin
    mrrs_bytes = 13'd4096;
    case (cfg_mrrs)
      3'd0:    mrrs_bytes = 13'd128;
      3'd1:    mrrs_bytes = 13'd256;
      3'd2:    mrrs_bytes = 13'd512;
      3'd3:    mrrs_bytes = 13'd1024;
      3'd4:    mrrs_bytes = 13'd2048;
      default: mrrs_bytes = 13'd4096;
    endcase
  end

  // Bytes left before the next 4 KB page boundary, 1..4096.
  assign bnd_bytes = 13'd4096 - {1'b0, cur_addr_q[11:0]};

  always_comb begin
    chunk_w = remaining_q;
    if (WIDTH'(mrrs_bytes) < chunk_w) chunk_w = WIDTH'(mrrs_bytes);
    if (WIDTH'(bnd_bytes) < chunk_w)  chunk_w = WIDTH'(bnd_bytes);
  end

  assign desc_ready = (state_q == IDLE);
  assign incb_valid = (state_q == ANNOUNCE);
  assign rq_valid   = (state_q == ISSUE) && !throttled;
  assign rq_last    = (state_q == ISSUE) && (remaining_q == WIDTH'(chunk_q));
  assign rq_hs      = rq_valid && rq_ready;
  assign busy       = (state_q != IDLE);

  assign incb_size  = remaining_q;
  assign incb_idx   = cur_idx_q;
  assign rq_addr    = cur_addr_q;
  assign rq_len_dw  = 11'(chunk_q >> 2);
  assign rq_idx     = cur_idx_q;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    cur_idx_d   = cur_idx_q;
    chunk_d     = chunk_q;
    case (state_q)
      IDLE: begin
        if (desc_valid) begin
          cur_addr_d  = {desc_addr[ADDR_WIDTH-1:2], 2'b00};
          remaining_d = {desc_size[WIDTH-1:2], 2'b00};
          cur_idx_d   = desc_idx;
          state_d     = ANNOUNCE;
        end
      end
      ANNOUNCE: begin
        if (incb_ready) state_d = (remaining_q == '0) ? IDLE : SPLIT;
      end
      SPLIT: begin
        chunk_d = 13'(chunk_w);
        state_d = ISSUE;
      end
      ISSUE: begin
        if (rq_hs) begin
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(chunk_q);
          remaining_d = remaining_q - WIDTH'(chunk_q);
          state_d     = rq_last ? IDLE : SPLIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_ul_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      cur_idx_q   <= '0;
      chunk_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      cur_idx_q   <= cur_idx_d;
      chunk_q     <= chunk_d;
    end
  end

`ifdef TX_REQ_OUTSTANDING_LIMIT_EN
  logic [3:0] outstanding_q, outstanding_d;
  logic       err_underflow_q, err_underflow_d;

  assign throttled = (outstanding_q >= 4'(MAX_OUTSTANDING));

  // A completion and an issue in the same cycle cancel out.
  always_comb begin
    outstanding_d   = outstanding_q;
    err_underflow_d = err_underflow_q;
    if (rq_hs && !cpl_done) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (cpl_done && !rq_hs && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
    if (cpl_done && (outstanding_q == 4'd0)) err_underflow_d = 1'b1;
  end

  always_ff @(posedge s_ul_clk) begin
    if (reset) begin
      outstanding_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      outstanding_q   <= outstanding_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign outstanding   = outstanding_q;
  assign err_underflow = err_underflow_q;
`else
  logic unused_cpl_done;

  // Tag credits live in the PCIe core; completions are not tracked here.
  assign unused_cpl_done = cpl_done;
  assign throttled       = 1'b0;
  assign outstanding     = 4'd0;
  assign err_underflow   = 1'b0;
`endif

endmodule

// File: tb/tb_tx_dma_req_split.sv
// Randomized bench for tx_dma_req_split against a queue-based split model; covers both builds of TX_REQ_OUTSTANDING_LIMIT_EN.
`timescale 1ns/1ps
module tb_tx_dma_req_split;
  localparam int W  = 16;
  localparam int AW = 32;
  localparam int MO = 2;

  logic          s_ul_clk = 1'b0;
  logic          reset;
  logic          desc_valid, desc_ready;
  logic [AW-1:0] desc_addr;
  logic [W-1:0]  desc_size;
  logic [4:0]    desc_idx;
  logic [2:0]    cfg_mrrs;
  logic          incb_valid, incb_ready;
  logic [W-1:0]  incb_size;
  logic [4:0]    incb_idx;
  logic          rq_valid, rq_ready;
  logic [AW-1:0] rq_addr;
  logic [10:0]   rq_len_dw;
  logic [4:0]    rq_idx;
  logic          rq_last;
  logic          cpl_done;
  logic [3:0]    outstanding;
  logic          busy, err_underflow;

  tx_dma_req_split #(.WIDTH(W), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .s_ul_clk(s_ul_clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_size(desc_size), .desc_idx(desc_idx), .cfg_mrrs(cfg_mrrs),
    .incb_valid(incb_valid), .incb_ready(incb_ready), .incb_size(incb_size), .incb_idx(incb_idx),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr), .rq_len_dw(rq_len_dw),
    .rq_idx(rq_idx), .rq_last(rq_last), .cpl_done(cpl_done), .outstanding(outstanding),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 s_ul_clk = ~s_ul_clk;

  int cyc = 0;
  always @(posedge s_ul_clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [10:0]   len;
    logic [4:0]    idx;
    logic          last;
  } rq_t;

  rq_t exp_q[$];
  rq_t obs_q[$];
  int n_chk = 0, n_pass = 0;
  int tb_out = 0;
  int viol, timed_out, incb_seen, incb_at1, incb_cyc, first_rqv_cyc, min_gap, last_hs_cyc;
  logic [W-1:0] obs_incb_size;
  logic [4:0]   obs_incb_idx;

  // Reference: walk the buffer, each piece bounded by remaining, MRRS and the 4 KB page end.
  function automatic void build_exp(input logic [AW-1:0] a, input logic [W-1:0] sz,
                                    input logic [2:0] mrrs, input logic [4:0] idx);
    int mb, rem, bnd, c;
    logic [AW-1:0] cur;
    rq_t e;
    exp_q.delete();
    mb  = 128 << ((int'(mrrs) > 5) ? 5 : int'(mrrs));
    rem = int'(sz);
    cur = a;
    while (rem > 0) begin
      bnd = 4096 - int'(cur % 4096);
      c = rem;
      if (mb < c)  c = mb;
      if (bnd < c) c = bnd;
      e.addr = cur; e.len = 11'(c / 4); e.idx = idx; e.last = (rem == c);
      exp_q.push_back(e);
      cur = cur + AW'(c);
      rem = rem - c;
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].len !== exp_q[i].len ||
          obs_q[i].idx !== exp_q[i].idx || obs_q[i].last !== exp_q[i].last) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Offers one descriptor and runs the handshakes, recording what the DUT produced.
  task automatic drive_desc(input logic [AW-1:0] a, input logic [W-1:0] sz, input logic [4:0] idx,
                            input int incb_hold, input int incb_pct, input int rq_pct,
                            input int cpl_pct, input int max_cyc);
    int budget, it;
    bit done, prev_rq_pend, prev_incb_pend;
    rq_t prev_rq, o;
    logic [W-1:0] prev_sz;
    logic [4:0] prev_ix;
    obs_q.delete();
    viol = 0; timed_out = 0; incb_seen = 0; incb_at1 = 0; incb_cyc = -1;
    first_rqv_cyc = -1; min_gap = 1000; last_hs_cyc = -1;
    prev_rq_pend = 0; prev_incb_pend = 0; prev_sz = '0; prev_ix = '0;
    prev_rq.addr = '0; prev_rq.len = '0; prev_rq.idx = '0; prev_rq.last = 1'b0;
    desc_addr = a; desc_size = sz; desc_idx = idx; desc_valid = 1'b1;
    budget = 0;
    @(negedge s_ul_clk);
    while (!desc_ready && budget < 50) begin @(negedge s_ul_clk); budget++; end
    @(posedge s_ul_clk); #1;
    desc_valid = 1'b0;
    done = 0; it = 0;
    while (!done && it < max_cyc) begin
      incb_ready = (it >= incb_hold) && ($urandom_range(99) < incb_pct);
      rq_ready   = ($urandom_range(99) < rq_pct);
      cpl_done   = (tb_out > 0) && ($urandom_range(99) < cpl_pct);
      @(negedge s_ul_clk);
`ifdef TX_REQ_OUTSTANDING_LIMIT_EN
      if (outstanding !== 4'(tb_out)) viol++;
      if (rq_valid && tb_out >= MO) viol++;
`else
      if (outstanding !== 4'd0 || err_underflow !== 1'b0) viol++;
`endif
      if (prev_rq_pend && (rq_valid !== 1'b1 || rq_addr !== prev_rq.addr || rq_len_dw !== prev_rq.len ||
                           rq_idx !== prev_rq.idx || rq_last !== prev_rq.last)) viol++;
      if (prev_incb_pend && (incb_valid !== 1'b1 || incb_size !== prev_sz || incb_idx !== prev_ix)) viol++;
      if (it < incb_hold && (incb_valid !== 1'b1 || rq_valid !== 1'b0)) viol++;
      if (it == 0) incb_at1 = incb_valid;
      prev_rq_pend = rq_valid && !rq_ready;
      prev_rq.addr = rq_addr; prev_rq.len = rq_len_dw; prev_rq.idx = rq_idx; prev_rq.last = rq_last;
      prev_incb_pend = incb_valid && !incb_ready;
      prev_sz = incb_size; prev_ix = incb_idx;
      if (incb_valid && incb_ready) begin
        incb_seen++; obs_incb_size = incb_size; obs_incb_idx = incb_idx; incb_cyc = cyc;
        if (sz[W-1:2] == '0) done = 1;
      end
      if (rq_valid && first_rqv_cyc < 0) first_rqv_cyc = cyc;
      if (rq_valid && rq_ready) begin
        o.addr = rq_addr; o.len = rq_len_dw; o.idx = rq_idx; o.last = rq_last;
        obs_q.push_back(o);
        if (last_hs_cyc >= 0 && cyc - last_hs_cyc < min_gap) min_gap = cyc - last_hs_cyc;
        last_hs_cyc = cyc;
        if (rq_last) done = 1;
      end
      tb_out = tb_out + ((rq_valid && rq_ready) ? 1 : 0) - (cpl_done ? 1 : 0);
      @(posedge s_ul_clk); #1;
      it++;
    end
    incb_ready = 1'b0; rq_ready = 1'b0; cpl_done = 1'b0;
    if (!done) timed_out = 1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (tb_out > 0 && k < 20) begin
      cpl_done = 1'b1;
      @(posedge s_ul_clk); #1;
      tb_out--; k++;
    end
    cpl_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge s_ul_clk);
    @(negedge s_ul_clk);
    n_chk++;
    if ({desc_ready, incb_valid, rq_valid, rq_last, busy, err_underflow, outstanding} !== 10'b10_0000_0000)
      $display("FAIL reset_ctrl: got %b required %b",
               {desc_ready, incb_valid, rq_valid, rq_last, busy, err_underflow, outstanding}, 10'b10_0000_0000);
    else n_pass++;
    n_chk++;
    if ({rq_addr, rq_len_dw, rq_idx, incb_size, incb_idx} !== '0)
      $display("FAIL reset_data: got %h required 0", {rq_addr, rq_len_dw, rq_idx, incb_size, incb_idx});
    else n_pass++;
    @(posedge s_ul_clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_mrrs_split();
    int d;
    cfg_mrrs = 3'd2;
    build_exp(32'h1000, 16'h0600, 3'd2, 5'd3);
    drive_desc(32'h1000, 16'h0600, 5'd3, 0, 100, 100, 100, 100);
    n_chk++;
    if ({incb_seen, obs_incb_size, obs_incb_idx} !== {32'd1, 16'h0600, 5'd3})
      $display("FAIL mrrs_incb: got n=%0d size=%h idx=%0d required n=1 size=600 idx=3",
               incb_seen, obs_incb_size, obs_incb_idx);
    else n_pass++;
    d = first_diff();
    n_chk++;
    if (d !== -1) $display("FAIL mrrs_reqs: differs at request %0d (got %0d requests, required %0d)",
                           d, obs_q.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if ({incb_at1 == 1, first_rqv_cyc - incb_cyc == 2, min_gap == 2, viol == 0, timed_out == 0} !== 5'b11111)
      $display("FAIL mrrs_timing: got incb_at1=%0d rq_delay=%0d gap=%0d viol=%0d timeout=%0d required 1 2 2 0 0",
               incb_at1, first_rqv_cyc - incb_cyc, min_gap, viol, timed_out);
    else n_pass++;
    @(negedge s_ul_clk);
    n_chk++;
    if (desc_ready !== 1'b1) $display("FAIL mrrs_ready_after_last: got %b required 1", desc_ready);
    else n_pass++;
    @(posedge s_ul_clk); #1;
    drain();
  endtask

  task automatic test_4k_boundary();
    int d;
    cfg_mrrs = 3'd5;
    build_exp(32'h0F80, 16'h0200, 3'd5, 5'd1);
    drive_desc(32'h0F80, 16'h0200, 5'd1, 0, 100, 100, 100, 100);
    d = first_diff();
    n_chk++;
    if (d !== -1 || viol != 0) $display("FAIL boundary_4k: differs at %0d (got %0d reqs, required %0d), viol=%0d",
                                        d, obs_q.size(), exp_q.size(), viol);
    else n_pass++;
    drain();
    cfg_mrrs = 3'd7;
    build_exp(32'hFFFF_FF80, 16'h0100, 3'd7, 5'd30);
    drive_desc(32'hFFFF_FF80, 16'h0100, 5'd30, 0, 100, 100, 100, 100);
    d = first_diff();
    n_chk++;
    if (d !== -1 || viol != 0) $display("FAIL addr_wrap: differs at %0d (got %0d reqs, required %0d), viol=%0d",
                                        d, obs_q.size(), exp_q.size(), viol);
    else n_pass++;
    drain();
  endtask

  task automatic test_backpressure_zero();
    int d;
    cfg_mrrs = 3'd0;
    build_exp(32'h0000_4000, 16'h0100, 3'd0, 5'd12);
    drive_desc(32'h0000_4000, 16'h0100, 5'd12, 5, 100, 100, 100, 100);
    d = first_diff();
    n_chk++;
    if (d !== -1 || viol != 0 || incb_seen != 1)
      $display("FAIL incb_backpressure: diff=%0d viol=%0d incb=%0d required -1 0 1", d, viol, incb_seen);
    else n_pass++;
    drain();
    exp_q.delete();
    drive_desc(32'h0000_8000, 16'h0000, 5'd21, 0, 100, 100, 100, 50);
    @(negedge s_ul_clk);
    n_chk++;
    if ({incb_seen == 1, obs_incb_size == 16'h0, obs_incb_idx == 5'd21, obs_q.size() == 0,
         desc_ready === 1'b1, timed_out == 0} !== 6'b111111)
      $display("FAIL zero_size: got incb=%0d size=%h idx=%0d reqs=%0d ready=%b required 1 0 21 0 1",
               incb_seen, obs_incb_size, obs_incb_idx, obs_q.size(), desc_ready);
    else n_pass++;
    @(posedge s_ul_clk); #1;
  endtask

  task automatic test_throttle();
    int d;
    drain();
    cfg_mrrs = 3'd1;
    build_exp(32'h2000, 16'h0300, 3'd1, 5'd7);
`ifdef TX_REQ_OUTSTANDING_LIMIT_EN
    drive_desc(32'h2000, 16'h0300, 5'd7, 0, 100, 100, 0, 30);
    @(negedge s_ul_clk);
    n_chk++;
    if ({obs_q.size() == 2, timed_out == 1, viol == 0, rq_valid === 1'b0, busy === 1'b1, outstanding === 4'd2}
        !== 6'b111111)
      $display("FAIL throttle_hold: got reqs=%0d rq_valid=%b outstanding=%0d viol=%0d required 2 0 2 0",
               obs_q.size(), rq_valid, outstanding, viol);
    else n_pass++;
    @(posedge s_ul_clk); #1;
    cpl_done = 1'b1;
    @(posedge s_ul_clk); #1;
    cpl_done = 1'b0;
    rq_ready = 1'b1;
    @(negedge s_ul_clk);
    n_chk++;
    if ({rq_valid, rq_addr, rq_len_dw, rq_last} !== {1'b1, 32'h2200, 11'd64, 1'b1})
      $display("FAIL throttle_release: got valid=%b addr=%h len=%0d last=%b required 1 2200 64 1",
               rq_valid, rq_addr, rq_len_dw, rq_last);
    else n_pass++;
    @(posedge s_ul_clk); #1;
    rq_ready = 1'b0;
    @(negedge s_ul_clk);
    n_chk++;
    if ({outstanding, desc_ready} !== {4'd2, 1'b1})
      $display("FAIL throttle_end: got outstanding=%0d ready=%b required 2 1", outstanding, desc_ready);
    else n_pass++;
    tb_out = 2;
    @(posedge s_ul_clk); #1;
`else
    drive_desc(32'h2000, 16'h0300, 5'd7, 0, 100, 100, 0, 100);
    d = first_diff();
    n_chk++;
    if (d !== -1 || viol != 0 || timed_out != 0)
      $display("FAIL no_throttle: diff=%0d reqs=%0d viol=%0d timeout=%0d required -1 3 0 0",
               d, obs_q.size(), viol, timed_out);
    else n_pass++;
`endif
    drain();
  endtask

  task automatic test_random(input int n, input int cpl_pct, input int rq_pct);
    logic [AW-1:0] a;
    logic [W-1:0] sz;
    logic [4:0] ix;
    int d;
    for (int k = 0; k < n; k++) begin
      a  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(2) == 0) a[11:0] = 12'hF00 + 12'($urandom_range(60) * 4);
      sz = 16'($urandom_range(16'h1400)) & 16'hFFFC;
      if ($urandom_range(9) == 0) sz = '0;
      ix = 5'($urandom);
      cfg_mrrs = 3'($urandom);
      build_exp(a, sz, cfg_mrrs, ix);
      drive_desc(a, sz, ix, 0, 60, rq_pct, cpl_pct, 2000);
      d = first_diff();
      n_chk++;
      if (d !== -1 || viol != 0 || timed_out != 0 || obs_incb_size !== sz || obs_incb_idx !== ix)
        $display("FAIL random_%0d: diff=%0d reqs=%0d/%0d viol=%0d timeout=%0d incb=%h/%0d required %h/%0d",
                 k, d, obs_q.size(), exp_q.size(), viol, timed_out, obs_incb_size, obs_incb_idx, sz, ix);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_underflow();
    logic exp_err;
`ifdef TX_REQ_OUTSTANDING_LIMIT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drain();
    cpl_done = 1'b1;
    @(posedge s_ul_clk); #1;
    cpl_done = 1'b0;
    @(negedge s_ul_clk);
    n_chk++;
    if ({err_underflow, outstanding} !== {exp_err, 4'd0})
      $display("FAIL underflow: got err=%b outstanding=%0d required %b 0", err_underflow, outstanding, exp_err);
    else n_pass++;
    repeat (4) @(negedge s_ul_clk);
    n_chk++;
    if (err_underflow !== exp_err) $display("FAIL underflow_sticky: got %b required %b", err_underflow, exp_err);
    else n_pass++;
    @(posedge s_ul_clk); #1;
  endtask

  task automatic test_reset_mid_issue();
    int d;
    cfg_mrrs = 3'd2;
    drive_desc(32'h3000, 16'h0600, 5'd4, 0, 100, 100, 0, 4);
    @(negedge s_ul_clk);
    n_chk++;
    if ({obs_q.size() == 1, rq_valid === 1'b1, busy === 1'b1} !== 3'b111)
      $display("FAIL mid_issue_setup: got reqs=%0d rq_valid=%b busy=%b required 1 1 1", obs_q.size(), rq_valid, busy);
    else n_pass++;
    @(posedge s_ul_clk); #1;
    reset = 1'b1;
    @(posedge s_ul_clk); #1;
    reset = 1'b0;
    tb_out = 0;
    @(negedge s_ul_clk);
    n_chk++;
    if ({busy, rq_valid, outstanding, err_underflow, desc_ready} !== 8'b0000_0001)
      $display("FAIL reset_mid_issue: got busy=%b rq_valid=%b outstanding=%0d err=%b ready=%b required 0 0 0 0 1",
               busy, rq_valid, outstanding, err_underflow, desc_ready);
    else n_pass++;
    @(posedge s_ul_clk); #1;
    cfg_mrrs = 3'd0;
    build_exp(32'h5000, 16'h0180, 3'd0, 5'd9);
    drive_desc(32'h5000, 16'h0180, 5'd9, 0, 100, 100, 100, 100);
    d = first_diff();
    n_chk++;
    if (d !== -1 || viol != 0 || obs_incb_size !== 16'h0180)
      $display("FAIL after_reset_desc: diff=%0d reqs=%0d/%0d viol=%0d size=%h required 180",
               d, obs_q.size(), exp_q.size(), viol, obs_incb_size);
    else n_pass++;
    drain();
  endtask

  initial begin
    reset = 1'b1; desc_valid = 1'b0; desc_addr = '0; desc_size = '0; desc_idx = '0;
    cfg_mrrs = 3'd0; incb_ready = 1'b0; rq_ready = 1'b0; cpl_done = 1'b0;
    test_reset();
    test_mrrs_split();
    test_4k_boundary();
    test_backpressure_zero();
    test_throttle();
    test_random(8, 40, 60);
    test_random(4, 70, 100);
    test_underflow();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tx_dma_req_split.md
# tx_dma_req_split

Upstream stage of the TX fill tracker in the PCIe TX DMA path. It accepts host buffer descriptors (bus address, byte size, buffer index). For each descriptor it first announces the expected size to the fill tracker over an `incb` handshake. It then splits the buffer into PCIe memory-read requests that never exceed the configured max read request size (MRRS) and never cross a 4 KB boundary. An outstanding-request counter throttles issue until completions retire.

## Interface
- `WIDTH`, 16: width of byte-size fields; must be ≥13.
- `ADDR_WIDTH`, 32: bus address width.
- `MAX_OUTSTANDING`, 8: limit on in-flight read requests, 1..15.

- `s_ul_clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock s_ul_clk.
- `desc_valid`  in  1  descriptor offered.
- `desc_ready`  out  1  descriptor accepted when high together with `desc_valid`.
- `desc_addr`  in  ADDR_WIDTH  buffer bus address; DWORD aligned, bits [1:0] ignored.
- `desc_size`  in  WIDTH  buffer size in bytes; multiple of 4, bits [1:0] ignored.
- `desc_idx`  in  5  buffer index.
- `cfg_mrrs`  in  3  PCIe MRRS encoding: 0=128 B … 5=4096 B; 6 and 7 are treated as 4096 B. Sampled in SPLIT.
- `incb_valid`  out  1  size announce to the fill tracker.
- `incb_ready`  in  1  fill-tracker accept.
- `incb_size`  out  WIDTH  announced size (the `desc_size` as captured).
- `incb_idx`  out  5  announced index.
- `rq_valid`  out  1  read request offered.
- `rq_ready`  in  1  request accepted.
- `rq_addr`  out  ADDR_WIDTH  request address, DWORD aligned.
- `rq_len_dw`  out  11  length in DWORDs, 1..1024, unencoded.
- `rq_idx`  out  5  buffer index of the request.
- `rq_last`  out  1  final request of the buffer.
- `cpl_done`  in  1  one-cycle pulse: one request fully completed.
- `outstanding`  out  4  in-flight request count.
- `busy`  out  1  high when state ≠ IDLE.
- `err_underflow`  out  1  sticky; set when `cpl_done` arrives with `outstanding`==0.

## Operation
- FSM states: IDLE, ANNOUNCE, SPLIT, ISSUE.
- IDLE:
  - `desc_ready`=1.
  - On accept, capture addr, size and idx into `cur_addr`, `remaining`, `cur_idx`; go to ANNOUNCE.
- ANNOUNCE:
  - `incb_valid`=1 with the captured size and idx.
  - On `incb_ready`: go to IDLE if size==0 (no requests are issued), otherwise go to SPLIT.
- SPLIT: register `chunk = min(remaining, mrrs_bytes, 4096 - cur_addr[11:0])`, then go to ISSUE.
- ISSUE:
  - Outputs: `rq_valid` = (limit not reached), `rq_addr`=`cur_addr`, `rq_len_dw`=`chunk`>>2, `rq_last` = (`remaining`==`chunk`).
  - On handshake: `cur_addr`+=`chunk`, `remaining`-=`chunk`. Go to IDLE if `rq_last`, else go to SPLIT.
- `rq_*` fields are stable while `rq_valid` is high and not yet accepted. `incb_*` fields are stable while `incb_valid` is high.
- Outstanding counter:
  - Increments on an `rq` handshake and decrements on `cpl_done`.
  - A simultaneous handshake and `cpl_done` leaves it unchanged.
  - `cpl_done` at 0 leaves it at 0 and sets `err_underflow`.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. `remaining` never underflows because `chunk` ≤ `remaining`.
- Reset in any state:
  - State → IDLE; `outstanding`=0; `err_underflow`=0.
  - The in-progress descriptor is dropped; requests already issued are not tracked.

## Timing
- Reset values: `desc_ready`=1, `incb_valid`=0, `rq_valid`=0, `rq_last`=0, `outstanding`=0, `busy`=0, `err_underflow`=0. `rq_addr`, `rq_len_dw`, `rq_idx`, `incb_size`, `incb_idx` reset to 0.
- Descriptor accept at cycle T → `incb_valid` high at T+1.
- `incb` handshake at cycle A → `rq_valid` high at A+2 at the earliest.
- Requests within a buffer issue at most every 2 cycles (SPLIT + ISSUE).
- After the last `rq` handshake at cycle L, `desc_ready`=1 at L+1.
- `outstanding` and `err_underflow` update one cycle after the causing event.
- Throttling is combinational on the registered count. A `cpl_done` at cycle C can release a stalled request at C+1.

## Configuration
- `TX_REQ_OUTSTANDING_LIMIT_EN` defined:
  - Outstanding counter, `MAX_OUTSTANDING` throttling and `err_underflow` are implemented as described above.
- Not defined:
  - `cpl_done` is ignored; `outstanding` and `err_underflow` are tied to 0.
  - `rq_valid` is never throttled; tag credits are handled by the PCIe core.

## Test plan
- MRRS split: cfg_mrrs=2 (512 B), addr 0x1000, size 0x600, idx 3 → `incb` carries 0x600/3, then three requests at 0x1000, 0x1200, 0x1400, each `rq_len_dw`=128, with `rq_last` only on the third.
- 4 KB boundary: cfg_mrrs=5, addr 0x0F80, size 0x200 → requests 0x0F80 with len 32, then 0x1000 with len 96 and `rq_last`=1.
- Throttle: `MAX_OUTSTANDING`=2, size 0x300, MRRS 256 B, no `cpl_done` → two requests issue and the third holds with `rq_valid`=0. One `cpl_done` pulse → third request issues the following cycle; `outstanding` ends at 2.
- Back-pressure and zero size: `incb_ready`=0 for 5 cycles → `incb_valid` stays high with stable fields and no `rq_valid`. A size-0 descriptor → one `incb` with size 0, no requests, and `desc_ready` high the next cycle.
- Underflow/simultaneous: `cpl_done` at `outstanding`=0 → `err_underflow`=1 (sticky), count stays 0. `cpl_done` coinciding with an `rq` handshake → count unchanged.
- Reset mid-ISSUE after one of three requests → next cycle: `busy`=0, `rq_valid`=0, `outstanding`=0; a new descriptor is then processed normally.
